// File: rtl/msrv32_dmem_ahb_master.sv
// msrv32_dmem_ahb_master: core data-memory requests to AHB-lite master transfers.
// Optional `MSRV32_DMEM_ERR_CANCEL_EN drops queued work on the first ERROR cycle.
module msrv32_dmem_ahb_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  input  logic        dmrd_req_in,
  input  logic [1:0]  dmrd_size_in,
  output logic        core_ready_out,
  output logic [31:0] rdata_out,
  output logic        rd_valid_out,
  output logic        err_out,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [3:0]  ahb_hprot_out,
  output logic [31:0] ahb_hwdata_out,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in,
  input  logic [31:0] ahb_hrdata_in
);
  logic        acc, xfer;
  logic [2:0]  wsize, rsize, nsize;
  logic [1:0]  woff;
  logic [31:0] naddr;
  logic        aph_valid, dph_valid, dph_write, pend_valid, pend_write, cancel_blk;
  logic [31:0] aph_data, pend_addr, pend_data;
  logic [2:0]  pend_size;
  always_comb begin
    wsize = (dmwr_mask_in == 4'b0011 || dmwr_mask_in == 4'b1100) ? 3'b001 :
            $onehot(dmwr_mask_in) ? 3'b000 : 3'b010;
    woff  = (dmwr_mask_in == 4'b0010) ? 2'd1 :
            (dmwr_mask_in == 4'b0100 || dmwr_mask_in == 4'b1100) ? 2'd2 :
            (dmwr_mask_in == 4'b1000) ? 2'd3 : 2'd0;
  end
  assign rsize          = (dmrd_size_in == 2'b11) ? 3'b010 : {1'b0, dmrd_size_in};
  assign nsize          = dmwr_req_in ? wsize : rsize;
  assign naddr          = dmwr_req_in ? {dmaddr_in[31:2], woff} : dmaddr_in;
  assign core_ready_out = !pend_valid && !cancel_blk;
  assign acc            = (dmwr_req_in || dmrd_req_in) && core_ready_out;
  // an all-zero write mask is accepted but never reaches the bus
  assign xfer           = acc && (dmwr_req_in ? |dmwr_mask_in : 1'b1);
  assign ahb_htrans_out = {aph_valid, 1'b0};
  assign ahb_hprot_out  = HPROT_VAL;
`ifndef MSRV32_DMEM_ERR_CANCEL_EN
  assign cancel_blk = 1'b0;
`endif
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      aph_valid      <= 1'b0;
      dph_valid      <= 1'b0;
      dph_write      <= 1'b0;
      pend_valid     <= 1'b0;
      pend_write     <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      pend_size      <= 3'b010;
      aph_data       <= '0;
      ahb_haddr_out  <= '0;
      ahb_hsize_out  <= 3'b010;
      ahb_hwrite_out <= 1'b0;
      ahb_hwdata_out <= '0;
      rdata_out      <= '0;
      rd_valid_out   <= 1'b0;
      err_out        <= 1'b0;
`ifdef MSRV32_DMEM_ERR_CANCEL_EN
      cancel_blk     <= 1'b0;
`endif
    end else begin
      rd_valid_out <= 1'b0;
      err_out      <= 1'b0;
      if (ahb_hready_in) begin
        if (dph_valid) begin
          err_out      <= ahb_hresp_in;
          rd_valid_out <= !ahb_hresp_in && !dph_write;
          if (!ahb_hresp_in && !dph_write) rdata_out <= ahb_hrdata_in;
        end
        dph_valid      <= aph_valid;
        dph_write      <= ahb_hwrite_out;
        ahb_hwdata_out <= aph_data;
        if (pend_valid) begin
          aph_valid      <= 1'b1;
          ahb_haddr_out  <= pend_addr;
          ahb_hsize_out  <= pend_size;
          ahb_hwrite_out <= pend_write;
          aph_data       <= pend_data;
          pend_valid     <= 1'b0;
        end else if (xfer) begin
          aph_valid      <= 1'b1;
          ahb_haddr_out  <= naddr;
          ahb_hsize_out  <= nsize;
          ahb_hwrite_out <= dmwr_req_in;
          aph_data       <= dmdata_in;
        end else begin
          aph_valid <= 1'b0;
        end
      end else if (xfer) begin
        pend_valid <= 1'b1;
        pend_addr  <= naddr;
        pend_size  <= nsize;
        pend_write <= dmwr_req_in;
        pend_data  <= dmdata_in;
      end
`ifdef MSRV32_DMEM_ERR_CANCEL_EN
      cancel_blk <= 1'b0;
      // first ERROR cycle: abandon everything queued behind the failing transfer
      if (dph_valid && !ahb_hready_in && ahb_hresp_in) begin
        aph_valid  <= 1'b0;
        pend_valid <= 1'b0;
        cancel_blk <= 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// tb_msrv32_dmem_ahb_master: directed and randomized checks against a queue-based
// transaction model of the AHB data-memory master.
module tb_msrv32_dmem_ahb_master;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] dmaddr = '0, dmdata = '0, hrdata = '0;
  logic [3:0]  mask = '0;
  logic        wr = 1'b0, rd = 1'b0, hready = 1'b1, hresp = 1'b0;
  logic [1:0]  rsz = '0;
  logic        core_ready, rd_valid, err, hwrite;
  logic [31:0] rdata, haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;

  always #5 clk = ~clk;

  msrv32_dmem_ahb_master dut (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n),
    .dmaddr_in(dmaddr), .dmdata_in(dmdata), .dmwr_mask_in(mask),
    .dmwr_req_in(wr), .dmrd_req_in(rd), .dmrd_size_in(rsz),
    .core_ready_out(core_ready), .rdata_out(rdata), .rd_valid_out(rd_valid), .err_out(err),
    .ahb_haddr_out(haddr), .ahb_htrans_out(htrans), .ahb_hwrite_out(hwrite),
    .ahb_hsize_out(hsize), .ahb_hprot_out(hprot), .ahb_hwdata_out(hwdata),
    .ahb_hready_in(hready), .ahb_hresp_in(hresp), .ahb_hrdata_in(hrdata)
  );

  typedef struct packed {logic w; logic [31:0] a; logic [2:0] s; logic [31:0] d;} xf_t;
  xf_t         q[$];
  xf_t         dx, it;
  bit          on_bus, dv, blk, e_rv, e_err, macc, mxfer, eflag;
  logic [31:0] e_rdata;
  int          checks = 0, failures = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic xf_t mk(input logic w, input logic [31:0] a, input logic [3:0] m,
                             input logic [1:0] rs, input logic [31:0] d);
    xf_t x;
    x.w = w; x.d = d; x.a = a;
    x.s = (rs == 2'b11) ? 3'd2 : {1'b0, rs};
    if (w) begin
      x.s = 3'd2;
      x.a = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++)
        if (m == (4'b0001 << i)) begin x.s = 3'd0; x.a[1:0] = i[1:0]; end
      if (m == 4'b0011) x.s = 3'd1;
      if (m == 4'b1100) begin x.s = 3'd1; x.a[1:0] = 2'd2; end
    end
    return x;
  endfunction

  function automatic bit ready_m();
    return (q.size() == int'(on_bus)) && !blk;
  endfunction

  // transaction model: queue of accepted transfers; head is on the bus when on_bus
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); on_bus = 0; dv = 0; blk = 0; e_rv = 0; e_err = 0; e_rdata = '0;
    end else begin
      macc  = (wr || rd) && ready_m();
      mxfer = macc && (!wr || mask != 4'b0000);
      it    = mk(wr, dmaddr, mask, rsz, dmdata);
      blk = 0; e_rv = 0; e_err = 0;
      if (hready) begin
        if (dv) begin
          if (hresp) e_err = 1;
          else if (!dx.w) begin e_rv = 1; e_rdata = hrdata; end
        end
        dv = on_bus;
        if (on_bus) dx = q.pop_front();
        if (mxfer) q.push_back(it);
        on_bus = q.size() > 0;
      end else begin
        if (mxfer) q.push_back(it);
`ifdef MSRV32_DMEM_ERR_CANCEL_EN
        if (dv && hresp) begin q.delete(); on_bus = 0; blk = 1; end
`endif
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("htrans", 32'(htrans), on_bus ? 32'd2 : 32'd0);
      if (on_bus) begin
        chk("haddr", haddr, q[0].a);
        chk("hsize", 32'(hsize), 32'(q[0].s));
        chk("hwrite", 32'(hwrite), 32'(q[0].w));
      end
      if (dv && dx.w) chk("hwdata", hwdata, dx.d);
      chk("rd_valid", 32'(rd_valid), 32'(e_rv));
      chk("err", 32'(err), 32'(e_err));
      chk("rdata", rdata, e_rdata);
      chk("core_ready", 32'(core_ready), 32'(ready_m()));
      chk("hprot", 32'(hprot), 32'h3);
    end
  end

  task automatic drv(input logic w, input logic r, input logic [3:0] m,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    wr = w; rd = r; mask = m; dmaddr = a; dmdata = d; rsz = s;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic rst_chk(input string n);
    chk({n, "_htrans"}, 32'(htrans), 32'd0);
    chk({n, "_haddr"}, haddr, 32'd0);
    chk({n, "_hsize"}, 32'(hsize), 32'd2);
    chk({n, "_hwrite"}, 32'(hwrite), 32'd0);
    chk({n, "_hwdata"}, hwdata, 32'd0);
    chk({n, "_rdata"}, rdata, 32'd0);
    chk({n, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({n, "_err"}, 32'(err), 32'd0);
    chk({n, "_core_ready"}, 32'(core_ready), 32'd1);
  endtask

  logic [3:0] masks [10] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h5, 4'h7};

  initial begin
    it = mk(1'b1, 32'h4, 4'b0010, 2'b00, 32'h0);
    chk("model_byte_addr", it.a, 32'h5);
    it = mk(1'b1, 32'h7, 4'b1100, 2'b00, 32'h0);
    chk("model_half_addr", it.a, 32'h6);
    it = mk(1'b0, 32'h13, 4'b0000, 2'b11, 32'h0);
    chk("model_rd_size11", 32'(it.s), 32'd2);
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;
    // word write
    drv(1, 0, 4'hF, 32'h8, 32'hAAAAAAAA, 0);
    @(negedge clk); idle();
    chk("ww_htrans", 32'(htrans), 32'd2); chk("ww_haddr", haddr, 32'h8);
    chk("ww_hsize", 32'(hsize), 32'd2); chk("ww_hwrite", 32'(hwrite), 32'd1);
    @(negedge clk);
    chk("ww_hwdata", hwdata, 32'hAAAAAAAA);
    // byte / half lanes and empty mask
    drv(1, 0, 4'b0010, 32'h4, 32'h11111111, 0);
    @(negedge clk);
    chk("b_haddr", haddr, 32'h5); chk("b_hsize", 32'(hsize), 32'd0);
    drv(1, 0, 4'b1100, 32'h4, 32'h22222222, 0);
    @(negedge clk);
    chk("h_haddr", haddr, 32'h6); chk("h_hsize", 32'(hsize), 32'd1);
    drv(1, 0, 4'b0000, 32'h4, 32'h33333333, 0);
    @(negedge clk); idle();
    chk("m0_htrans", 32'(htrans), 32'd0);
    // word read
    hrdata = 32'h12345678;
    drv(0, 1, 4'h0, 32'h10, 32'h0, 2'b10);
    @(negedge clk); idle();
    chk("rd_htrans", 32'(htrans), 32'd2); chk("rd_haddr", haddr, 32'h10);
    chk("rd_hwrite", 32'(hwrite), 32'd0);
    @(negedge clk); chk("rd_early", 32'(rd_valid), 32'd0);
    @(negedge clk); chk("rd_pulse", 32'(rd_valid), 32'd1); chk("rd_data", rdata, 32'h12345678);
    @(negedge clk); chk("rd_once", 32'(rd_valid), 32'd0);
    // wait states with a pending request
    drv(1, 0, 4'hF, 32'h20, 32'hD0000020, 0);
    @(negedge clk); drv(1, 0, 4'hF, 32'h24, 32'hD0000024, 0);
    @(negedge clk); drv(1, 0, 4'hF, 32'h28, 32'hD0000028, 0); hready = 1'b0;
    repeat (3) begin
      @(negedge clk); idle();
      chk("ws_ready", 32'(core_ready), 32'd0); chk("ws_haddr", haddr, 32'h24);
    end
    hready = 1'b1;
    @(negedge clk);
    chk("ws_haddr3", haddr, 32'h28); chk("ws_hwdata2", hwdata, 32'hD0000024);
    chk("ws_ready1", 32'(core_ready), 32'd1);
    @(negedge clk); chk("ws_hwdata3", hwdata, 32'hD0000028);
    // two-cycle ERROR on a write with a queued transfer behind it
    drv(1, 0, 4'hF, 32'h30, 32'hE0000030, 0);
    @(negedge clk); drv(1, 0, 4'hF, 32'h34, 32'hE0000034, 0);
    @(negedge clk); idle(); hready = 1'b0; hresp = 1'b1;
    @(negedge clk);
    chk("e1_err", 32'(err), 32'd0);
`ifdef MSRV32_DMEM_ERR_CANCEL_EN
    chk("e1_htrans", 32'(htrans), 32'd0); chk("e1_ready", 32'(core_ready), 32'd0);
`else
    chk("e1_htrans", 32'(htrans), 32'd2); chk("e1_haddr", haddr, 32'h34);
`endif
    hready = 1'b1;
    @(negedge clk); hresp = 1'b0;
    chk("e2_err", 32'(err), 32'd1);
`ifndef MSRV32_DMEM_ERR_CANCEL_EN
    chk("e2_hwdata", hwdata, 32'hE0000034);
`endif
    @(negedge clk); chk("e3_err", 32'(err), 32'd0);
    // reset mid data phase with a pending request
    hrdata = 32'hDEADBEEF;
    drv(0, 1, 4'h0, 32'h40, 32'h0, 2'b10);
    @(negedge clk); drv(1, 0, 4'hF, 32'h44, 32'hF0000044, 0);
    @(negedge clk); drv(1, 0, 4'hF, 32'h48, 32'hF0000048, 0); hready = 1'b0;
    @(negedge clk); idle();
    chk("pr_ready", 32'(core_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 rst_chk("midrst");
    hready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rv", 32'(rd_valid), 32'd0); chk("post_err", 32'(err), 32'd0);
    end
    // randomized traffic with wait states and two-cycle errors
    eflag = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (eflag) begin hready = 1'b1; hresp = 1'b1; eflag = 0; end
      else if (dv && $urandom_range(11) == 0) begin hready = 1'b0; hresp = 1'b1; eflag = 1; end
      else begin hresp = 1'b0; hready = dv ? ($urandom_range(3) != 0) : 1'b1; end
      begin
        int r;
        r = int'($urandom_range(7));
        drv(r < 3, r >= 2 && r < 5, masks[$urandom_range(9)], $urandom, $urandom,
            2'($urandom_range(3)));
      end
      hrdata = $urandom;
    end
    @(negedge clk);
    idle(); hready = 1'b1; hresp = 1'b0;
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
